// File: rtl/img_pkg.sv
// Shared image geometry and window-generator FSM state encoding.
// med_filter and its bench reuse OUT_N from here.
package img_pkg;

  localparam int unsigned IMG_W  = 224;
  localparam int unsigned IMG_H  = 224;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned OUT_W  = IMG_W - 2;
  localparam int unsigned OUT_H  = IMG_H - 2;
  localparam int unsigned OUT_N  = OUT_W * OUT_H;
  localparam int unsigned PIX_N  = IMG_W * IMG_H;
  localparam int unsigned COL_W  = $clog2(IMG_W);
  localparam int unsigned ROW_W  = $clog2(IMG_H);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wg_state_e;

  // Next column position of the incoming pixel, wrapping at the line end.
  function automatic logic [COL_W-1:0] col_next(input logic [COL_W-1:0] col);
    if (col == COL_W'(IMG_W - 1)) begin
      return '0;
    end else begin
      return col + COL_W'(1);
    end
  endfunction

endpackage

// File: rtl/window_gen_3x3_line_buffer.sv
// line_buffer: DEPTH-entry circular delay line. o_dout is the sample pushed
// exactly DEPTH pushes ago; it is read before the slot is overwritten.
module line_buffer #(
  parameter int unsigned DEPTH = 224,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;

  assign o_dout = r_mem[r_ptr];

  // Wrapping pointer; advances once per pushed pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_en) begin
      if (r_ptr == PTR_W'(DEPTH - 1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= r_ptr + PTR_W'(1);
      end
    end
  end

  // Storage is never cleared; window validity comes from the counters.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[r_ptr] <= i_din;
    end
  end

endmodule

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: streams the source image out of the ROM in raster order and
// emits one 3x3 neighbourhood per interior pixel, tagged with its output index.
module window_gen_3x3
  import img_pkg::*;
(
  input  logic                 clk_25,
  input  logic                 rst,
  input  logic                 start,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [PIX_W-1:0]     rom_data,
  output logic [9*PIX_W-1:0]   win,
  output logic                 win_valid,
  output logic [ADDR_W-1:0]    win_addr,
  output logic                 busy,
  output logic                 done
);

  wg_state_e         r_state;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_drain;
  logic              r_busy;
  logic              r_done;

  logic              r_pix_valid;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_next_idx;
  logic [ADDR_W-1:0] r_win_addr;
  logic              r_win_valid;
  logic [PIX_W-1:0]  r_sr [3][3];

  logic [PIX_W-1:0]  w_lb1;
  logic [PIX_W-1:0]  w_lb2;
  logic              w_win_ok;

  assign rom_addr  = r_rom_addr;
  assign win_valid = r_win_valid;
  assign win_addr  = r_win_addr;
  assign busy      = r_busy;
  assign done      = r_done;

  // r_row/r_col describe the pixel currently on rom_data.
  assign w_win_ok = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_r1 (
    .clk    (clk_25),
    .rst    (rst),
    .i_en   (r_pix_valid),
    .i_din  (rom_data),
    .o_dout (w_lb1)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_r2 (
    .clk    (clk_25),
    .rst    (rst),
    .i_en   (r_pix_valid),
    .i_din  (w_lb1),
    .o_dout (w_lb2)
  );

  // Frame sequencer: address generation, drain, busy/done.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rom_addr <= '0;
      r_drain    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rom_addr <= '0;
          r_done     <= 1'b0;
          if (start) begin
            r_state <= FETCH;
            r_busy  <= 1'b1;
          end
        end
        FETCH: begin
          if (r_rom_addr == LAST_ADDR) begin
            r_state <= DRAIN;
            r_drain <= 1'b0;
          end else begin
            r_rom_addr <= r_rom_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (r_drain) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_drain <= 1'b1;
          end
        end
        DONE: begin
          r_state    <= IDLE;
          r_done     <= 1'b0;
          r_rom_addr <= '0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Pixel tracking, 3x3 shift register and window tagging.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      r_pix_valid <= 1'b0;
      r_col       <= '0;
      r_row       <= '0;
      r_next_idx  <= '0;
      r_win_addr  <= '0;
      r_win_valid <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          r_sr[i][j] <= '0;
        end
      end
    end else begin
      r_pix_valid <= (r_state == FETCH);
      r_win_valid <= r_pix_valid && w_win_ok;

      if (r_state == IDLE) begin
        r_col      <= '0;
        r_row      <= '0;
        r_next_idx <= '0;
      end else if (r_pix_valid) begin
        r_col <= col_next(r_col);
        if (r_col == COL_W'(IMG_W - 1)) begin
          r_row <= r_row + ROW_W'(1);
        end
        if (w_win_ok) begin
          r_next_idx <= r_next_idx + ADDR_W'(1);
        end
      end

      if (r_pix_valid) begin
        for (int i = 0; i < 3; i++) begin
          r_sr[i][0] <= r_sr[i][1];
          r_sr[i][1] <= r_sr[i][2];
        end
        r_sr[0][2] <= w_lb2;
        r_sr[1][2] <= w_lb1;
        r_sr[2][2] <= rom_data;
        if (w_win_ok) begin
          r_win_addr <= r_next_idx;
        end
      end
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    for (genvar gj = 0; gj < 3; gj++) begin : g_col
      assign win[PIX_W*(3*gi+gj) +: PIX_W] = r_sr[gi][gj];
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3 against a synchronous ramp/constant ROM model.
module tb_window_gen_3x3;

  typedef struct {
    int          addr;
    logic [71:0] exp;
  } vec_t;

  localparam int NV = 5;

  logic        clk_25;
  logic        rst;
  logic        start;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic [71:0] win;
  logic        win_valid;
  logic [15:0] win_addr;
  logic        busy;
  logic        done;

  bit          konst;
  int          n_checks;
  int          n_errors;

  int          n_valid, seq_err, data_err, a450_cyc, first_cyc;
  int          c221, c222, last_valid_cyc, done_cyc, ndone, timeout;
  logic        busy_last, busy_done;
  logic [15:0] last_addr;
  vec_t        vecs [NV];
  logic [71:0] cap [NV];
  logic        cap_ok [NV];

  window_gen_3x3 dut (
    .clk_25    (clk_25),
    .rst       (rst),
    .start     (start),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .win       (win),
    .win_valid (win_valid),
    .win_addr  (win_addr),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk_25 = 1'b0;
    forever #5 clk_25 = ~clk_25;
  end

  // Synchronous ROM: data for the address presented one cycle earlier.
  always @(posedge clk_25) begin
    rom_data <= konst ? 8'h5A : rom_addr[7:0];
  end

  function automatic logic [71:0] mkwin(input int p00, input int p01, input int p02,
                                        input int p10, input int p11, input int p12,
                                        input int p20, input int p21, input int p22);
    return {8'(p22), 8'(p21), 8'(p20), 8'(p12), 8'(p11), 8'(p10), 8'(p02), 8'(p01), 8'(p00)};
  endfunction

  function automatic logic [71:0] exp_win(input int a);
    logic [71:0] w;
    int r0;
    int c0;
    r0 = a / 222;
    c0 = a % 222;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w[8*(3*i+j) +: 8] = konst ? 8'h5A : 8'((r0 + i) * 224 + c0 + j);
      end
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Starts a frame at the current negedge and monitors it until done, an abort
  // address (rst is then raised) or the cycle budget runs out.
  task automatic run_frame(input bit repulse, input int abort_addr);
    int cyc;
    bit fin;
    n_valid = 0; seq_err = 0; data_err = 0; a450_cyc = -1; first_cyc = -1;
    c221 = -1; c222 = -1; last_valid_cyc = -1; done_cyc = -1; ndone = 0;
    timeout = 0; busy_last = 1'b0; busy_done = 1'b1; last_addr = '0;
    for (int i = 0; i < NV; i++) cap_ok[i] = 1'b0;
    cyc = 0;
    fin = 1'b0;
    start = 1'b1;
    while (!fin) begin
      @(negedge clk_25);
      cyc++;
      if (busy && rom_addr == 16'd450 && a450_cyc < 0) a450_cyc = cyc;
      if (win_valid) begin
        if (n_valid == 0) first_cyc = cyc;
        if (win_addr !== 16'(n_valid)) seq_err++;
        if (win !== exp_win(n_valid)) data_err++;
        for (int i = 0; i < NV; i++) begin
          if (vecs[i].addr == n_valid) begin
            cap[i] = win;
            cap_ok[i] = 1'b1;
          end
        end
        if (n_valid == 221) c221 = cyc;
        if (n_valid == 222) c222 = cyc;
        last_addr = win_addr;
        last_valid_cyc = cyc;
        busy_last = busy;
        n_valid++;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
        busy_done = busy;
        fin = 1'b1;
      end
      if (abort_addr > 0 && rom_addr == 16'(abort_addr)) begin
        rst = 1'b1;
        fin = 1'b1;
      end
      if (cyc >= 60000) begin
        timeout = 1;
        fin = 1'b1;
      end
      start = (repulse && cyc == 1000) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    konst    = 1'b0;
    rst      = 1'b1;
    start    = 1'b0;

    vecs[0] = '{0,     mkwin(0, 1, 2, 224, 225, 226, 192, 193, 194)};
    vecs[1] = '{221,   mkwin(221, 222, 223, 189, 190, 191, 157, 158, 159)};
    vecs[2] = '{222,   mkwin(224, 225, 226, 192, 193, 194, 160, 161, 162)};
    vecs[3] = '{1000,  mkwin(240, 241, 242, 208, 209, 210, 176, 177, 178)};
    vecs[4] = '{49283, mkwin(61, 62, 63, 29, 30, 31, 253, 254, 255)};

    repeat (3) @(negedge clk_25);
    chk("reset_rom_addr",  rom_addr,  16'd0);
    chk("reset_win",       win,       72'd0);
    chk("reset_win_valid", win_valid, 1'b0);
    chk("reset_win_addr",  win_addr,  16'd0);
    chk("reset_busy",      busy,      1'b0);
    chk("reset_done",      done,      1'b0);

    // rst and start together: rst must win
    start = 1'b1;
    @(negedge clk_25);
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk_25);
    chk("rst_start_busy",     busy,     1'b0);
    chk("rst_start_rom_addr", rom_addr, 16'd0);

    // Full ramp frame with a stray start pulse at cycle 1000
    run_frame(1'b1, 0);
    chk("f1_timeout",      timeout, 0);
    chk("f1_first_lat",    first_cyc - a450_cyc, 2);
    chk("f1_count",        n_valid, 49284);
    chk("f1_last_addr",    last_addr, 16'd49283);
    chk("f1_addr_seq",     seq_err, 0);
    chk("f1_data",         data_err, 0);
    chk("f1_row_gap",      c222 - c221, 3);
    chk("f1_done_gap",     done_cyc - last_valid_cyc, 1);
    chk("f1_busy_at_last", busy_last, 1'b1);
    chk("f1_busy_at_done", busy_done, 1'b0);
    for (int i = 0; i < NV; i++) begin
      chk($sformatf("f1_captured@%0d", vecs[i].addr), cap_ok[i], 1'b1);
      chk($sformatf("f1_win@%0d", vecs[i].addr), cap[i], vecs[i].exp);
    end
    repeat (3) begin
      @(negedge clk_25);
      if (done) ndone++;
    end
    chk("f1_done_pulses", ndone, 1);
    chk("f1_idle_rom_addr", rom_addr, 16'd0);
    chk("f1_idle_busy", busy, 1'b0);

    // Constant ROM frame, reset mid-frame
    konst = 1'b1;
    run_frame(1'b0, 4000);
    @(negedge clk_25);
    chk("mid_rst_win_valid", win_valid, 1'b0);
    chk("mid_rst_busy",      busy,      1'b0);
    chk("mid_rst_rom_addr",  rom_addr,  16'd0);
    chk("mid_rst_done",      done,      1'b0);
    rst = 1'b0;
    chk("f2_count",   n_valid, 3519);
    chk("f2_data_5a", data_err, 0);
    chk("f2_addr_seq", seq_err, 0);

    // Restart after the reset: first windows must be fresh ramp windows
    konst = 1'b0;
    @(negedge clk_25);
    run_frame(1'b0, 500);
    @(negedge clk_25);
    rst = 1'b0;
    chk("f3_first_lat", first_cyc - a450_cyc, 2);
    chk("f3_captured0", cap_ok[0], 1'b1);
    chk("f3_win0",      cap[0], vecs[0].exp);
    chk("f3_count",     n_valid, 49);
    chk("f3_addr_seq",  seq_err, 0);
    chk("f3_data",      data_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
